// File: rtl/conv_pkg.sv
// Shared width defaults and FSM state encoding for the conv accumulate/requantize block.
package conv_pkg;

    localparam int PRODUCT_DATA_WIDTH_DEF = 32;
    localparam int OUT_DATA_WIDTH_DEF     = 8;
    localparam int ACC_CNT_WIDTH_DEF      = 10;
    localparam int MULT_WIDTH_DEF         = 16;
    localparam int SHIFT_WIDTH            = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCALE = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/requant_sat.sv
// Round-half-up arithmetic right shift followed by saturation to the output range.
// Defining CONV_POST_RELU_EN clamps the lower bound to zero (ReLU).
module requant_sat
    import conv_pkg::*;
#(
    parameter int IN_WIDTH  = PRODUCT_DATA_WIDTH_DEF + MULT_WIDTH_DEF + 1,
    parameter int OUT_WIDTH = OUT_DATA_WIDTH_DEF
) (
    input  logic signed [IN_WIDTH-1:0]    prod,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic signed [OUT_WIDTH-1:0]   result
);

    localparam logic signed [IN_WIDTH-1:0] MAX_V = (IN_WIDTH'(1) << (OUT_WIDTH - 1)) - IN_WIDTH'(1);
`ifdef CONV_POST_RELU_EN
    localparam logic signed [IN_WIDTH-1:0] MIN_V = '0;
`else
    localparam logic signed [IN_WIDTH-1:0] MIN_V = -MAX_V - IN_WIDTH'(1);
`endif

    logic signed [IN_WIDTH-1:0] rnd;
    logic signed [IN_WIDTH-1:0] rounded;
    logic signed [IN_WIDTH-1:0] shifted;

    always_comb begin
        rnd = '0;
        if (shift != '0) begin
            rnd = IN_WIDTH'(1) << (shift - 1'b1);
        end
        rounded = prod + rnd;
        shifted = rounded >>> shift;
        if (shifted > MAX_V) begin
            result = MAX_V[OUT_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            result = MIN_V[OUT_WIDTH-1:0];
        end else begin
            result = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/conv_accum_requant.sv
// Accumulates acc_len signed conv partial sums, adds bias, scales, rounds, saturates.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// the producer holds data stable while valid is high and ready is low.
// Build option CONV_POST_RELU_EN selects ReLU saturation inside requant_sat.
module conv_accum_requant
    import conv_pkg::*;
#(
    parameter int PRODUCT_DATA_WIDTH = PRODUCT_DATA_WIDTH_DEF,
    parameter int OUT_DATA_WIDTH     = OUT_DATA_WIDTH_DEF,
    parameter int ACC_CNT_WIDTH      = ACC_CNT_WIDTH_DEF,
    parameter int MULT_WIDTH         = MULT_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_load_i,
    input  logic [ACC_CNT_WIDTH-1:0]      cfg_acc_len_i,
    input  logic [PRODUCT_DATA_WIDTH-1:0] cfg_bias_i,
    input  logic [MULT_WIDTH-1:0]         cfg_mult_i,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    input  logic [PRODUCT_DATA_WIDTH-1:0] in_data_i,
    output logic                          in_ready_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [OUT_DATA_WIDTH-1:0]     out_data_o,
    output logic                          busy_o,
    output state_t                        dbg_state
);

    localparam int PW     = PRODUCT_DATA_WIDTH;
    localparam int MW     = MULT_WIDTH;
    localparam int PROD_W = PW + MW + 1;

    state_t state, state_nxt;

    logic [ACC_CNT_WIDTH-1:0] len_q;
    logic [PW-1:0]            bias_q;
    logic [MW-1:0]            mult_q;
    logic [SHIFT_WIDTH-1:0]   shift_q;
    logic [PW-1:0]            acc_q;
    logic [ACC_CNT_WIDTH-1:0] cnt_q;
    logic                     scale_ph;
    logic signed [PROD_W-1:0] p_q;

    logic in_fire, out_fire, flush_act, cfg_take, last_in;
    logic signed [PW:0]           biased;
    logic signed [PROD_W:0]       prod_full;
    logic signed [OUT_DATA_WIDTH-1:0] sat_q;

    assign in_fire   = in_valid_i & in_ready_o;
    assign out_fire  = out_valid_o & out_ready_i;
    assign flush_act = flush_i & (state != ST_IDLE);
    assign cfg_take  = cfg_load_i & ~flush_i &
                       ((state == ST_IDLE) | ((state == ST_ACCUM) & (cnt_q == '0)));
    assign last_in   = in_fire & ((cnt_q + ACC_CNT_WIDTH'(1)) == len_q);

    // Bias add is one bit wider than acc so the product never wraps.
    assign biased    = {acc_q[PW-1], acc_q} + {bias_q[PW-1], bias_q};
    assign prod_full = biased * $signed({1'b0, mult_q});

    requant_sat #(
        .IN_WIDTH  (PROD_W),
        .OUT_WIDTH (OUT_DATA_WIDTH)
    ) u_requant_sat (
        .prod   (p_q),
        .shift  (shift_q),
        .result (sat_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cfg_take) state_nxt = ST_ACCUM;
            ST_ACCUM: if (!flush_act && last_in) state_nxt = ST_SCALE;
            ST_SCALE: begin
                if (flush_act)     state_nxt = ST_ACCUM;
                else if (scale_ph) state_nxt = ST_OUT;
            end
            ST_OUT:   if (flush_act || out_fire) state_nxt = ST_ACCUM;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = (state == ST_ACCUM);
        busy_o     = (state != ST_IDLE);
        dbg_state  = state;
    end

    // SCALE spends one cycle registering the product and one requantizing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            bias_q      <= '0;
            mult_q      <= '0;
            shift_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            scale_ph    <= 1'b0;
            p_q         <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
        end else if (flush_act) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            scale_ph    <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            if (cfg_take) begin
                len_q   <= (cfg_acc_len_i == '0) ? ACC_CNT_WIDTH'(1) : cfg_acc_len_i;
                bias_q  <= cfg_bias_i;
                mult_q  <= cfg_mult_i;
                shift_q <= cfg_shift_i;
            end
            case (state)
                ST_ACCUM: begin
                    if (in_fire) begin
                        acc_q <= acc_q + in_data_i;
                        cnt_q <= cnt_q + ACC_CNT_WIDTH'(1);
                    end
                end
                ST_SCALE: begin
                    if (!scale_ph) begin
                        p_q      <= prod_full[PROD_W-1:0];
                        scale_ph <= 1'b1;
                    end else begin
                        out_data_o  <= sat_q;
                        out_valid_o <= 1'b1;
                        scale_ph    <= 1'b0;
                    end
                end
                ST_OUT: begin
                    if (out_fire) begin
                        out_valid_o <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_accum_requant.sv
// Randomized and directed bench for conv_accum_requant against an arithmetic reference model.
module tb_conv_accum_requant;
    import conv_pkg::*;

    localparam int PW = 32;
    localparam int OW = 8;
    localparam int CW = 10;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_load_i = 1'b0;
    logic [CW-1:0] cfg_acc_len_i = '0;
    logic [PW-1:0] cfg_bias_i = '0;
    logic [MW-1:0] cfg_mult_i = '0;
    logic [4:0]    cfg_shift_i = '0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic [PW-1:0] in_data_i = '0;
    logic          in_ready_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [OW-1:0] out_data_o;
    logic          busy_o;
    state_t        dbg_state;

    conv_accum_requant dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_load_i    (cfg_load_i),
        .cfg_acc_len_i (cfg_acc_len_i),
        .cfg_bias_i    (cfg_bias_i),
        .cfg_mult_i    (cfg_mult_i),
        .cfg_shift_i   (cfg_shift_i),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_data_i     (in_data_i),
        .in_ready_o    (in_ready_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .busy_o        (busy_o),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [OW-1:0] exp_q[$];
    logic          rand_ready = 1'b0;

    // reference model state
    int                 len_m = 1;
    longint             bias_m = 0;
    longint             mult_m = 1;
    int                 shift_m = 0;
    logic signed [PW-1:0] acc_m = '0;
    int                 cnt_m = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint model(input logic signed [PW-1:0] sum);
        longint p, r, hi, lo;
        p = (longint'(sum) + bias_m) * mult_m;
        if (shift_m > 0) p = p + (longint'(1) << (shift_m - 1));
        r  = p >>> shift_m;
        hi = 127;
`ifdef CONV_POST_RELU_EN
        lo = 0;
`else
        lo = -128;
`endif
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic do_cfg(input int len, input longint bias, input longint mult, input int shift);
        cfg_acc_len_i = CW'(len);
        cfg_bias_i    = PW'(bias);
        cfg_mult_i    = MW'(mult);
        cfg_shift_i   = 5'(shift);
        cfg_load_i    = 1'b1;
        tick();
        cfg_load_i = 1'b0;
        len_m   = (len == 0) ? 1 : len;
        bias_m  = bias;
        mult_m  = mult;
        shift_m = shift;
    endtask

    task automatic send_value(input logic signed [PW-1:0] d);
        int guard = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        while (!in_ready_o && guard < 500) begin
            tick();
            guard++;
        end
        if (!in_ready_o) check("in_ready_timeout", 0, 1);
        tick();
        in_valid_i = 1'b0;
        acc_m = acc_m + d;
        cnt_m++;
        if (cnt_m == len_m) begin
            exp_q.push_back(OW'(model(acc_m)));
            acc_m = '0;
            cnt_m = 0;
        end
    endtask

    task automatic do_flush(input logic with_cfg);
        flush_i       = 1'b1;
        cfg_load_i    = with_cfg;
        cfg_acc_len_i = CW'(1);
        tick();
        flush_i    = 1'b0;
        cfg_load_i = 1'b0;
        acc_m = '0;
        cnt_m = 0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid_o || !in_ready_o) && guard < 2000) begin
            tick();
            guard++;
        end
        check("drain_timeout", guard < 2000, 1);
    endtask

    // scoreboard: compare every output handshake against the expected queue
    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", $signed(out_data_o), 999);
            end else begin
                check("out_data", $signed(out_data_o), $signed(exp_q.pop_front()));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready_i = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        repeat (3) tick();
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_in_ready", in_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        tick();

        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("idle_flush_busy", busy_o, 0);
        check("idle_flush_ready", in_ready_o, 0);

        // single input, unity scale, latency
        do_cfg(1, 0, 1, 0);
        check("cfg_busy", busy_o, 1);
        check("cfg_ready", in_ready_o, 1);
        send_value(5);
        check("lat_t0_valid", out_valid_o, 0);
        tick();
        check("lat_t1_valid", out_valid_o, 0);
        tick();
        check("lat_t2_valid", out_valid_o, 1);
        check("lat_t2_data", $signed(out_data_o), 5);
        drain();

        // three-input accumulate with bias, scale and rounding
        do_cfg(3, -4, 3, 2);
        send_value(10); send_value(20); send_value(30);
        drain();

        // backpressure holds result
        out_ready_i = 1'b0;
        send_value(10); send_value(20); send_value(30);
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid_o, 1);
            check("bp_data", $signed(out_data_o), 42);
            check("bp_in_ready", in_ready_o, 0);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        check("bp_released", out_valid_o, 0);
        drain();

        // saturation and rounding corners
        do_cfg(0, 0, 1, 0);
        send_value(1000); send_value(-50);
        drain();
        do_cfg(1, 0, 1, 2);
        send_value(6); send_value(-6);
        drain();

        // flush mid-accumulation, with a cfg_load that must be ignored
        do_cfg(3, 0, 1, 0);
        send_value(7); send_value(7);
        do_flush(1'b1);
        check("flush_ready", in_ready_o, 1);
        check("flush_valid", out_valid_o, 0);
        send_value(1); send_value(2); send_value(3);
        drain();

        // randomized transactions
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int len = $urandom_range(0, 4);
            longint bias = longint'($urandom_range(0, 2000)) - 1000;
            longint mult = ($urandom_range(0, 4) == 0) ? longint'($urandom_range(0, 65535))
                                                       : longint'($urandom_range(0, 300));
            drain();
            do_cfg(len, bias, mult, $urandom_range(0, 16));
            for (int k = 0; k < ((len == 0) ? 1 : len); k++) begin
                logic signed [PW-1:0] d;
                if ($urandom_range(0, 3) == 0) d = $urandom();
                else d = PW'(int'($urandom_range(0, 4000)) - 2000);
                repeat ($urandom_range(0, 2)) tick();
                send_value(d);
                if (cnt_m != 0 && $urandom_range(0, 9) == 0) begin
                    do_flush(1'b0);
                    k = -1;
                end
            end
        end
        drain();
        rand_ready  = 1'b0;
        #2 out_ready_i = 1'b0;

        // reset mid-operation discards the pending result
        do_cfg(1, 0, 1, 0);
        send_value(9);
        repeat (3) tick();
        check("pre_rst_valid", out_valid_o, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        exp_q.delete();
        acc_m = '0;
        cnt_m = 0;
        tick();
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        tick();
        check("post_rst_state", dbg_state, ST_IDLE);
        do_cfg(2, 0, 1, 0);
        send_value(3); send_value(4);
        drain();
        check("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
